// File: rtl/debounce_fsm_module.sv
// Debouncer for an asynchronous, bouncing input: two-flop synchronizer feeding a
// four-state qualification FSM that emits a debounced level and a rising-edge strobe.
module debounce_fsm_module #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_in,
    output logic       level,
    output logic       pulse,
    output logic [1:0] state,
    output logic [1:0] next_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RISE_CHK = 2'b01,
        HIGH     = 2'b10,
        FALL_CHK = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_level;
    logic             r_pulse;
    logic             w_level_next;
    logic             w_pulse_next;
    logic             w_cnt_last;

    assign w_cnt_last = (r_cnt == LAST_CNT);

    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would chain sync1 into sync2 in one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_pulse <= w_pulse_next;
        end
    end

    // Counter only advances while a check is still short of qualification, so it cannot wrap.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        w_next_state = r_state;
        w_cnt_next   = '0;
        if (!rst) begin
            w_next_state = IDLE;
        end else begin
            unique case (r_state)
                IDLE:     if (r_sync2) w_next_state = RISE_CHK;
                RISE_CHK: begin
                    if (!r_sync2)        w_next_state = IDLE;
                    else if (w_cnt_last) w_next_state = HIGH;
                    else                 w_cnt_next   = r_cnt + CNT_W'(1);
                end
                HIGH:     if (!r_sync2) w_next_state = FALL_CHK;
                FALL_CHK: begin
                    if (r_sync2)         w_next_state = HIGH;
                    else if (w_cnt_last) w_next_state = IDLE;
                    else                 w_cnt_next   = r_cnt + CNT_W'(1);
                end
                default:  w_next_state = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the upcoming state so the registered copies line up with r_state.
    always_comb begin
        w_level_next = (w_next_state == HIGH) || (w_next_state == FALL_CHK);
        w_pulse_next = (r_state == RISE_CHK) && (w_next_state == HIGH);
    end

    assign state      = r_state;
    assign next_state = w_next_state;
    assign level      = r_level;
    assign pulse      = r_pulse;

endmodule

// File: doc/debounce_fsm_module.md
DEBOUNCE_FSM_MODULE -- requirements
Module: debounce_fsm_module

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 4, meaning consecutive synchronized samples required to accept a level change (legal range 1..255).
REQ-002 SHALL provide parameter CNT_W, default 8, meaning width of the internal stability counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low (rst=0 at a rising clk edge resets the block).
REQ-005 raw_in  input  1  asynchronous, possibly bouncing level (push-button or external line).
REQ-006 level  output  1  debounced level, registered.
REQ-007 pulse  output  1  single-cycle strobe on each accepted rising edge; drives the downstream counter/FSM `in` input.
REQ-008 state  output  2  current FSM state, registered.
REQ-009 next_state  output  2  combinational next-state value.

Function
REQ-010 SHALL pass raw_in through a two-flop synchronizer (sync1 -> sync2); s = sync2 is the only value used by the FSM.
REQ-011 SHALL implement a Moore FSM with encodings IDLE=2'b00, RISE_CHK=2'b01, HIGH=2'b10, FALL_CHK=2'b11.
REQ-012 IDLE: s=1 -> RISE_CHK with cnt cleared to 0; else stay.
REQ-013 RISE_CHK: s=0 -> IDLE (glitch rejected, no pulse); s=1 and cnt==STABLE_CYCLES-1 -> HIGH; s=1 otherwise -> stay, cnt+1.
REQ-014 HIGH: s=0 -> FALL_CHK with cnt cleared to 0; else stay.
REQ-015 FALL_CHK: s=1 -> HIGH (glitch rejected, level unchanged); s=0 and cnt==STABLE_CYCLES-1 -> IDLE; s=0 otherwise -> stay, cnt+1.
REQ-016 level SHALL be 1 exactly while state is HIGH or FALL_CHK.
REQ-017 pulse SHALL be 1 for exactly the first cycle state==HIGH after a RISE_CHK->HIGH transition; FALL_CHK->HIGH SHALL NOT produce a pulse.
REQ-018 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap; it holds 0 in IDLE and HIGH.
REQ-019 Latency: raw_in stable from sampling edge k -> state enters RISE_CHK at edge k+2; HIGH, level=1 and pulse=1 at edge k+2+STABLE_CYCLES; falling path symmetric for level.
REQ-020 STABLE_CYCLES=1 SHALL yield exactly one cycle in RISE_CHK/FALL_CHK.
REQ-021 next_state SHALL equal the value state takes at the next rising edge when rst=1.

Reset
REQ-022 On rst=0 at a rising edge: sync1=0, sync2=0, state=IDLE, cnt=0, level=0, pulse=0; next_state SHALL read IDLE while rst=0.
REQ-023 Reset SHALL override any in-progress check; after release with raw_in held high, a full RISE_CHK qualification and one pulse SHALL follow (no pulse suppression).
REQ-024 Reset asserted during the pulse cycle SHALL clear pulse at that same edge.

Verification
REQ-025 rst=0 for 2 cycles, raw_in=0 -> state=00, level=0, pulse=0, next_state=00 throughout.
REQ-026 STABLE_CYCLES=4, raw_in 0->1 held -> RISE_CHK 2 edges after first sample, HIGH/level=1/pulse=1 at edge k+6, pulse=0 at k+7.
REQ-027 raw_in high 3 cycles then low (STABLE_CYCLES=4) -> RISE_CHK then IDLE, level=0, pulse never 1.
REQ-028 From HIGH, raw_in low 2 cycles then high -> FALL_CHK then HIGH, level stays 1, no pulse.
REQ-029 Two clean presses separated by 10 idle cycles -> exactly two pulses, each 1 cycle wide; downstream 3-bit counter advances by 2.
REQ-030 rst=0 asserted mid-RISE_CHK with raw_in high, released after 1 cycle -> IDLE, then re-qualification, pulse at 2+STABLE_CYCLES edges after release.
